// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: instruction-memory fetch handshake.
//   imem_req   : fetch request (sequencer -> memory)
//   imem_addr  : fetch address (sequencer -> memory)
//   imem_ready : instruction for imem_addr available this cycle (memory -> sequencer)
interface pc_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;

  modport master (output imem_req, output imem_addr, input  imem_ready);
  modport slave  (input  imem_req, input  imem_addr, output imem_ready);
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-sequencing controller for the program counter.
// All state updates on the falling edge of clk, matching the PC register.
// Ports:
//   clk, reset (async, active low)
//   start_pc        : boot address, loaded while reset is low
//   imem            : fetch handshake (master side)
//   stall           : hazard hold, blocks PC advance
//   branch_taken/branch_target, jump/jump_target : redirects (jump wins)
//   exc_req         : exception request, redirects to EXC_VECTOR
//   halt / resume   : enter / leave HALTED
//   pc_cur          : current PC (registered)
//   pc_next         : value pc_cur takes at the next falling edge (combinational)
//   pc_valid        : one-cycle pulse, an instruction retired at the previous edge
//   exc_epc         : PC of the instruction that took the last exception
//   state           : BOOT=0, FETCH=1, HALTED=2
module pc_sequencer #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] start_pc,
  pc_sequencer_if.master    imem,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              exc_req,
  input  logic              halt,
  input  logic              resume,
  output logic [ADDR_W-1:0] pc_cur,
  output logic [ADDR_W-1:0] pc_next,
  output logic              pc_valid,
  output logic [ADDR_W-1:0] exc_epc,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  // Word alignment: low two address bits are dropped from every external address.
  localparam logic [ADDR_W-1:0] ALIGN_M = {{(ADDR_W-2){1'b1}}, 2'b00};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] epc_q;
  logic              vld_q;
  logic              req_q;

  logic [ADDR_W-1:0] start_al;
  logic              adv;
  logic              exc_take;

  assign start_al = start_pc & ALIGN_M;

  // Exceptions are honoured in FETCH and HALTED only, independent of ready/stall.
  assign exc_take = exc_req && (state_q != ST_BOOT);
  assign adv      = (state_q == ST_FETCH) && imem.imem_ready && !stall && !exc_req;

  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    if (exc_take) begin
      pc_d    = EXC_VECTOR;
      state_d = ST_FETCH;
    end else begin
      case (state_q)
        ST_BOOT:  state_d = ST_FETCH;
        ST_FETCH: begin
          if (adv) begin
            if (jump)              pc_d = jump_target & ALIGN_M;
            else if (branch_taken) pc_d = branch_target & ALIGN_M;
            else                   pc_d = pc_q + ADDR_W'(4);
            if (halt) state_d = ST_HALTED;
          end
        end
        ST_HALTED: if (resume) state_d = ST_FETCH;
        default:   state_d = ST_BOOT;
      endcase
    end
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_BOOT;
      pc_q    <= start_al;
      epc_q   <= '0;
      vld_q   <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      vld_q   <= adv;
      // Request tracks the state being entered so it is a clean register output.
      req_q   <= (state_d == ST_FETCH);
      if (exc_take) epc_q <= pc_q;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign pc_cur         = pc_q;
  assign pc_next        = reset ? pc_d : start_al;
  assign pc_valid       = vld_q;
  assign exc_epc        = epc_q;
  assign state          = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] start_pc;
  logic        stall, branch_taken, jump, exc_req, halt, resume;
  logic [31:0] branch_target, jump_target;
  logic [31:0] pc_cur, pc_next, exc_epc;
  logic        pc_valid;
  logic [1:0]  state;

  pc_sequencer_if #(.ADDR_W(32)) imem_bus ();

  pc_sequencer #(.ADDR_W(32), .EXC_VECTOR(32'h0000_0080)) dut (
    .clk(clk), .reset(reset), .start_pc(start_pc), .imem(imem_bus),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .exc_req(exc_req),
    .halt(halt), .resume(resume), .pc_cur(pc_cur), .pc_next(pc_next),
    .pc_valid(pc_valid), .exc_epc(exc_epc), .state(state)
  );

  always #5 clk = ~clk;

  // Control bits: ready, stall, branch, jump, exc, halt, resume
  localparam logic [6:0] N = 7'b0000000;
  localparam logic [6:0] R = 7'b1000000;
  localparam logic [6:0] S = 7'b0100000;
  localparam logic [6:0] B = 7'b0010000;
  localparam logic [6:0] J = 7'b0001000;
  localparam logic [6:0] E = 7'b0000100;
  localparam logic [6:0] H = 7'b0000010;
  localparam logic [6:0] U = 7'b0000001;

  typedef struct {
    logic [6:0]  ctl;
    logic [31:0] bt;
    logic [31:0] jt;
    logic [31:0] exp_next;
    logic [31:0] exp_pc;
    logic [1:0]  exp_st;
    logic        exp_vld;
    logic        exp_req;
    logic [31:0] exp_epc;
  } vec_t;

  vec_t tbl [32];
  vec_t sb [$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    imem_bus.imem_ready = v.ctl[6];
    stall               = v.ctl[5];
    branch_taken        = v.ctl[4];
    jump                = v.ctl[3];
    exc_req             = v.ctl[2];
    halt                = v.ctl[1];
    resume              = v.ctl[0];
    branch_target       = v.bt;
    jump_target         = v.jt;
  endtask

  // Drive at the rising edge, check pc_next before the falling edge, then check
  // the registered results at the following rising edge.
  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    drive(v);
    #1;
    chk($sformatf("v%0d.pc_next", idx), pc_next, v.exp_next);
    sb.push_back(v);
    @(negedge clk);
    @(posedge clk);
    e = sb.pop_front();
    chk($sformatf("v%0d.pc_cur", idx),    pc_cur,                      e.exp_pc);
    chk($sformatf("v%0d.imem_addr", idx), imem_bus.imem_addr,          e.exp_pc);
    chk($sformatf("v%0d.state", idx),     {30'd0, state},              {30'd0, e.exp_st});
    chk($sformatf("v%0d.pc_valid", idx),  {31'd0, pc_valid},           {31'd0, e.exp_vld});
    chk($sformatf("v%0d.imem_req", idx),  {31'd0, imem_bus.imem_req},  {31'd0, e.exp_req});
    chk($sformatf("v%0d.exc_epc", idx),   exc_epc,                     e.exp_epc);
  endtask

  initial begin
    // boot and sequential fetch
    tbl[0]  = '{R,     32'h0,   32'h0,        32'h400, 32'h400, 2'd1, 1'b0, 1'b1, 32'h0};
    tbl[1]  = '{R,     32'h0,   32'h0,        32'h404, 32'h404, 2'd1, 1'b1, 1'b1, 32'h0};
    tbl[2]  = '{R,     32'h0,   32'h0,        32'h408, 32'h408, 2'd1, 1'b1, 1'b1, 32'h0};
    tbl[3]  = '{R,     32'h0,   32'h0,        32'h40C, 32'h40C, 2'd1, 1'b1, 1'b1, 32'h0};
    // redirect priority (misaligned targets get low bits cleared)
    tbl[4]  = '{R|J,   32'h0,   32'h101,      32'h100, 32'h100, 2'd1, 1'b1, 1'b1, 32'h0};
    tbl[5]  = '{R|J|B, 32'h300, 32'h200,      32'h200, 32'h200, 2'd1, 1'b1, 1'b1, 32'h0};
    tbl[6]  = '{R|B,   32'h302, 32'h0,        32'h300, 32'h300, 2'd1, 1'b1, 1'b1, 32'h0};
    tbl[7]  = '{R|J,   32'h0,   32'h208,      32'h208, 32'h208, 2'd1, 1'b1, 1'b1, 32'h0};
    // exception beats stall and jump
    tbl[8]  = '{R|S|J|E, 32'h0, 32'h500,      32'h80,  32'h80,  2'd1, 1'b0, 1'b1, 32'h208};
    // wait then stall
    tbl[9]  = '{R|J,   32'h0,   32'h40,       32'h40,  32'h40,  2'd1, 1'b1, 1'b1, 32'h208};
    tbl[10] = '{J,     32'h0,   32'h999,      32'h40,  32'h40,  2'd1, 1'b0, 1'b1, 32'h208};
    tbl[11] = '{N,     32'h0,   32'h0,        32'h40,  32'h40,  2'd1, 1'b0, 1'b1, 32'h208};
    tbl[12] = '{N,     32'h0,   32'h0,        32'h40,  32'h40,  2'd1, 1'b0, 1'b1, 32'h208};
    tbl[13] = '{R|S|B, 32'h700, 32'h0,        32'h40,  32'h40,  2'd1, 1'b0, 1'b1, 32'h208};
    tbl[14] = '{R|S,   32'h0,   32'h0,        32'h40,  32'h40,  2'd1, 1'b0, 1'b1, 32'h208};
    tbl[15] = '{R,     32'h0,   32'h0,        32'h44,  32'h44,  2'd1, 1'b1, 1'b1, 32'h208};
    // halt / resume
    tbl[16] = '{R|J,   32'h0,   32'h10,       32'h10,  32'h10,  2'd1, 1'b1, 1'b1, 32'h208};
    tbl[17] = '{R|H,   32'h0,   32'h0,        32'h14,  32'h14,  2'd2, 1'b1, 1'b0, 32'h208};
    tbl[18] = '{R|J,   32'h0,   32'h900,      32'h14,  32'h14,  2'd2, 1'b0, 1'b0, 32'h208};
    tbl[19] = '{R|H,   32'h0,   32'h0,        32'h14,  32'h14,  2'd2, 1'b0, 1'b0, 32'h208};
    tbl[20] = '{R,     32'h0,   32'h0,        32'h14,  32'h14,  2'd2, 1'b0, 1'b0, 32'h208};
    tbl[21] = '{N,     32'h0,   32'h0,        32'h14,  32'h14,  2'd2, 1'b0, 1'b0, 32'h208};
    tbl[22] = '{U,     32'h0,   32'h0,        32'h14,  32'h14,  2'd1, 1'b0, 1'b1, 32'h208};
    tbl[23] = '{R|U,   32'h0,   32'h0,        32'h18,  32'h18,  2'd1, 1'b1, 1'b1, 32'h208};
    tbl[24] = '{R|H,   32'h0,   32'h0,        32'h1C,  32'h1C,  2'd2, 1'b1, 1'b0, 32'h208};
    // exception from HALTED beats resume; exception while not ready
    tbl[25] = '{E|U,   32'h0,   32'h0,        32'h80,  32'h80,  2'd1, 1'b0, 1'b1, 32'h1C};
    tbl[26] = '{E,     32'h0,   32'h0,        32'h80,  32'h80,  2'd1, 1'b0, 1'b1, 32'h80};
    // wrap
    tbl[27] = '{R|J,   32'h0,   32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 2'd1, 1'b1, 1'b1, 32'h80};
    tbl[28] = '{R,     32'h0,   32'h0,        32'h0,   32'h0,   2'd1, 1'b1, 1'b1, 32'h80};
    tbl[29] = '{R,     32'h0,   32'h0,        32'h4,   32'h4,   2'd1, 1'b1, 1'b1, 32'h80};
    // after mid-run reset: exception in BOOT ignored, then normal advance
    tbl[30] = '{R|E,   32'h0,   32'h0,        32'h600, 32'h600, 2'd1, 1'b0, 1'b1, 32'h0};
    tbl[31] = '{R,     32'h0,   32'h0,        32'h604, 32'h604, 2'd1, 1'b1, 1'b1, 32'h0};

    reset = 1'b0;
    start_pc = 32'h0000_0403;
    drive(tbl[11]);
    repeat (2) @(posedge clk);
    chk("rst.pc_cur",   pc_cur,                     32'h400);
    chk("rst.pc_next",  pc_next,                    32'h400);
    chk("rst.state",    {30'd0, state},             32'd0);
    chk("rst.pc_valid", {31'd0, pc_valid},          32'd0);
    chk("rst.imem_req", {31'd0, imem_bus.imem_req}, 32'd0);
    chk("rst.exc_epc",  exc_epc,                    32'h0);
    reset = 1'b1;
    #1;
    chk("boot.pc_next", pc_next, 32'h400);
    chk("boot.state",   {30'd0, state}, 32'd0);

    for (int i = 0; i < 30; i++) apply(tbl[i], i);

    // Mid-fetch reset between edges: takes effect without a clock edge.
    drive(tbl[0]);
    start_pc = 32'h0000_0601;
    #2;
    reset = 1'b0;
    #1;
    chk("mid.pc_cur",   pc_cur,                     32'h600);
    chk("mid.pc_next",  pc_next,                    32'h600);
    chk("mid.state",    {30'd0, state},             32'd0);
    chk("mid.pc_valid", {31'd0, pc_valid},          32'd0);
    chk("mid.imem_req", {31'd0, imem_bus.imem_req}, 32'd0);
    chk("mid.exc_epc",  exc_epc,                    32'h0);
    @(posedge clk);
    reset = 1'b1;
    for (int i = 30; i < 32; i++) apply(tbl[i], i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Fetch-sequencing controller for the program counter register. It decides each cycle whether the PC holds or advances, and to which address: sequential PC+4, branch, jump, or exception vector. It handshakes with instruction memory and drives the PC register's next-address input. It also supports halt/resume and records the exception return address.

Parameters:
ADDR_W, 32, address width in bits.
EXC_VECTOR, 32'h0000_0080, exception redirect address.

Ports:
clk  in  1  system clock; all state updates on the falling edge, matching the PC register.
reset  in  1  asynchronous, active-low reset.
start_pc  in  ADDR_W  boot address, loaded while reset=0.
imem_req  out  1  fetch request to instruction memory.
imem_addr  out  ADDR_W  fetch address; always equals pc_cur.
imem_ready  in  1  instruction for imem_addr is available this cycle.
stall  in  1  hazard hold; blocks PC advance.
branch_taken  in  1  take branch_target at the advance edge.
branch_target  in  ADDR_W  branch destination.
jump  in  1  take jump_target at the advance edge.
jump_target  in  ADDR_W  jump destination.
exc_req  in  1  exception request.
halt  in  1  halt after the current instruction completes.
resume  in  1  leave HALTED.
pc_cur  out  ADDR_W  current PC (registered).
pc_next  out  ADDR_W  combinational; the value pc_cur takes at the next falling edge. Feeds the PC register's next-address input.
pc_valid  out  1  registered one-cycle pulse: an instruction retired at the previous edge.
exc_epc  out  ADDR_W  PC of the instruction that took the last exception.
state  out  2  BOOT=0, FETCH=1, HALTED=2.

Behaviour:
- Reset (reset=0, asynchronous): pc_cur=start_pc, state=BOOT, pc_valid=0, exc_epc=0.
  - imem_req=0 and pc_next=start_pc while in reset.
  - Reset asserted mid-fetch aborts the fetch immediately.
- BOOT: next falling edge -> FETCH. pc_cur unchanged; imem_req=0.
- FETCH: imem_req=1, imem_addr=pc_cur.
  - Advance edge = falling edge with imem_ready=1, stall=0, exc_req=0.
  - Next-PC priority at the advance edge: jump > branch_taken > pc_cur+4.
  - pc_valid=1 in the cycle following an advance edge; 0 otherwise.
  - imem_ready=1 with stall=1: no advance; pc_cur holds; pc_valid=0; request stays asserted.
  - imem_ready=0: pc_cur holds; jump/branch inputs ignored.
  - halt=1 at an advance edge: pc_cur takes the computed next PC; state -> HALTED.
- HALTED: imem_req=0; pc_cur holds.
  - resume=1 -> FETCH.
  - halt and resume are ignored outside their states.
- Exception:
  - exc_req=1 at any falling edge in FETCH or HALTED, regardless of imem_ready or stall: exc_epc<=pc_cur, pc_cur<=EXC_VECTOR, state->FETCH, pc_valid=0.
  - Exception beats jump, branch, halt and resume in the same cycle.
  - exc_req in BOOT is ignored.
- Arithmetic and alignment:
  - pc_cur+4 wraps modulo 2^ADDR_W: 32'hFFFF_FFFC -> 0.
  - Bits [1:0] of branch_target, jump_target and start_pc are forced to 00 before use.
- pc_next always equals the value pc_cur will take at the next falling edge:
  - pc_cur when holding;
  - the selected target on an advance or exception edge;
  - start_pc in reset.
- Latency: one instruction per cycle when imem_ready=1 continuously and stall=0.

Test Plan:
- Boot: start_pc=32'h0000_0400, release reset, imem_ready=1 constant -> state 0 then 1. pc_cur sequence 400, 404, 408, 40C. pc_valid high from the cycle after the first advance.
- Redirect priority: at pc_cur=0x100, jump=1 (target 0x200) and branch_taken=1 (target 0x300) on the same edge -> pc_cur=0x200. Next edge with only branch (target 0x302) -> pc_cur=0x300.
- Stall/wait: imem_ready=0 for 3 cycles, then stall=1 for 2 cycles with imem_ready=1 -> pc_cur holds 0x40 for all 5 cycles, pc_valid=0, imem_req=1 throughout, then advances to 0x44.
- Exception: at pc_cur=0x208, assert exc_req with stall=1 and jump=1 -> pc_cur=0x80, exc_epc=0x208, pc_valid=0, state=FETCH.
- Halt/resume: halt=1 at the advance edge from 0x10 -> pc_cur=0x14, state=2, imem_req=0. pc_cur holds 0x14 for 4 cycles. resume=1 -> state=1, fetch 0x14.
- Wrap and reset mid-run: pc_cur=0xFFFF_FFFC advances to 0x0. Asserting reset between edges forces pc_cur=start_pc and imem_req=0 immediately, without waiting for a clock edge.
